ghr_spec_controller: RTL and testbench

Sequences speculative and committed updates of the TAGE global branch history. Accepts one predicted branch per cycle, shifts the predicted direction into the speculative history presented to the tagged tables, and holds each prediction in an in-order outstanding-branch queue. On in-order resolution it advances the committed history. On a misprediction it restores the speculative history from the corrected committed history and flushes all younger outstanding branches.

---
 rtl/ghr_ctrl_pkg.sv | 22 ++
 rtl/branch_outcome_fifo.sv | 54 +++++
 rtl/ghr_spec_controller.sv | 92 +++++++++
 tb/tb_ghr_spec_controller.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ghr_ctrl_pkg.sv
// Shared definitions for the global-history speculation controller:
// controller states and the history shift rule also used by the predictor.
package ghr_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    localparam int GHL_MAX = 64;

    // Newest outcome enters at bit len-1 and the LSB drops out; callers
    // pass a zero-extended history of length len and cast the result back.
    function automatic logic [GHL_MAX-1:0] hist_shift(
        input logic [GHL_MAX-1:0] h,
        input logic               b,
        input int unsigned        len
    );
        return (h >> 1) | (GHL_MAX'(b) << (len - 1));
    endfunction

endpackage

// File: rtl/branch_outcome_fifo.sv
// In-order queue of predicted directions for outstanding branches, with a
// single-cycle flush used when a misprediction squashes all younger entries.
module branch_outcome_fifo #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          din,
    input  logic          pop,
    input  logic          flush,
    output logic          dout,
    output logic [PW-1:0] wr_ptr,
    output logic [PW:0]   count
);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;

    // NOTE: the storage array carries no reset; an entry is only ever read
    // after it was written, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

    // NOTE: state flops use non-blocking assignments so every register in
    // the design samples pre-edge values regardless of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/ghr_spec_controller.sv
// Speculative / committed global history sequencing for a TAGE predictor,
// with in-order resolution and one-cycle recovery after a misprediction.
module ghr_spec_controller
    import ghr_ctrl_pkg::*;
#(
    parameter  int GHL   = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pred_valid,
    input  logic           pred_taken,
    output logic           pred_ready,
    output logic [PW-1:0]  pred_tag,
    input  logic           res_valid,
    input  logic           res_taken,
    output logic [GHL-1:0] ghr_spec,
    output logic [GHL-1:0] ghr_commit,
    output logic           mispredict,
    output logic [PW:0]    outstanding,
    output logic           res_err
);

    state_t         state, state_next;
    logic           accept, resolve, wrong;
    logic           queued_taken;
    logic [GHL-1:0] spec_shifted, commit_shifted;

    assign accept  = pred_valid && pred_ready;
    assign resolve = res_valid && (state == ST_RUN) && (outstanding != '0);
    assign wrong   = resolve && (queued_taken != res_taken);

    assign spec_shifted   = GHL'(hist_shift(GHL_MAX'(ghr_spec), pred_taken, GHL));
    assign commit_shifted = GHL'(hist_shift(GHL_MAX'(ghr_commit), res_taken, GHL));

    // A squashed accept is simply never pushed; the flush wins anyway.
    branch_outcome_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (accept && !wrong),
        .din    (pred_taken),
        .pop    (resolve && !wrong),
        .flush  (wrong),
        .dout   (queued_taken),
        .wr_ptr (pred_tag),
        .count  (outstanding)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    // NOTE: defaulting next-state first keeps this block free of latches.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:     if (wrong) state_next = ST_RECOVER;
            ST_RECOVER: state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    always_comb begin
        pred_ready = 1'b0;
        if (state == ST_RUN)
            pred_ready = (outstanding < (PW+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_spec   <= '0;
            ghr_commit <= '0;
            mispredict <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            if (wrong)
                ghr_spec <= commit_shifted;
            else if (accept)
                ghr_spec <= spec_shifted;
            if (resolve)
                ghr_commit <= commit_shifted;
            mispredict <= wrong;
            if (res_valid && ((state == ST_RECOVER) || (outstanding == '0)))
                res_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ghr_spec_controller.sv
// Directed-vector bench: the driver queues hand-computed expectations and a
// separate monitor pops and compares them against the DUT outputs.
module tb_ghr_spec_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pred_valid = 1'b0, pred_taken = 1'b0;
    logic       res_valid = 1'b0, res_taken = 1'b0;
    logic       pred_ready, mispredict, res_err;
    logic [1:0] pred_tag;
    logic [7:0] ghr_spec, ghr_commit;
    logic [2:0] outstanding;

    ghr_spec_controller #(.GHL(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_ready  (pred_ready),
        .pred_tag    (pred_tag),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .ghr_spec    (ghr_spec),
        .ghr_commit  (ghr_commit),
        .mispredict  (mispredict),
        .outstanding (outstanding),
        .res_err     (res_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] spec;
        logic [7:0] commit;
        logic [2:0] outst;
        logic       mis;
        logic       ready;
        logic [1:0] tag;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares every queued expectation against the settled outputs.
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, ".ghr_spec"},    32'(ghr_spec),    32'(e.spec));
                check({e.name, ".ghr_commit"},  32'(ghr_commit),  32'(e.commit));
                check({e.name, ".outstanding"}, 32'(outstanding), 32'(e.outst));
                check({e.name, ".mispredict"},  32'(mispredict),  32'(e.mis));
                check({e.name, ".pred_ready"},  32'(pred_ready),  32'(e.ready));
                check({e.name, ".pred_tag"},    32'(pred_tag),    32'(e.tag));
                check({e.name, ".res_err"},     32'(res_err),     32'(e.err));
            end
        end
    end

    task automatic expect_state(input string name, input logic [7:0] spec, input logic [7:0] commit,
                                input logic [2:0] outst, input logic mis, input logic ready,
                                input logic [1:0] tag, input logic err);
        exp_t e;
        e.name = name; e.spec = spec; e.commit = commit; e.outst = outst;
        e.mis = mis; e.ready = ready; e.tag = tag; e.err = err;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus followed by the expected post-edge state.
    task automatic step(input string name, input logic pv, input logic pt, input logic rv, input logic rt,
                        input logic [7:0] spec, input logic [7:0] commit, input logic [2:0] outst,
                        input logic mis, input logic ready, input logic [1:0] tag, input logic err);
        @(negedge clk);
        pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
        @(posedge clk);
        #1;
        pred_valid = 1'b0; pred_taken = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
        expect_state(name, spec, commit, outst, mis, ready, tag, err);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_state("reset", 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 2'd0, 1'b0);

        //    name            pv pt rv rt  spec   commit out mis rdy tag err
        step("acc_t0",        1, 1, 0, 0, 8'h80, 8'h00, 3'd1, 0, 1, 2'd1, 0);
        step("acc_n1",        1, 0, 0, 0, 8'h40, 8'h00, 3'd2, 0, 1, 2'd2, 0);
        step("acc_t2",        1, 1, 0, 0, 8'hA0, 8'h00, 3'd3, 0, 1, 2'd3, 0);
        step("res_t0",        0, 0, 1, 1, 8'hA0, 8'h80, 3'd2, 0, 1, 2'd3, 0);
        step("res_n1",        0, 0, 1, 0, 8'hA0, 8'h40, 3'd1, 0, 1, 2'd3, 0);
        step("res_t2",        0, 0, 1, 1, 8'hA0, 8'hA0, 3'd0, 0, 1, 2'd3, 0);

        step("fill_n_wrap",   1, 0, 0, 0, 8'h50, 8'hA0, 3'd1, 0, 1, 2'd0, 0);
        step("fill_n",        1, 0, 0, 0, 8'h28, 8'hA0, 3'd2, 0, 1, 2'd1, 0);
        step("fill_t",        1, 1, 0, 0, 8'h94, 8'hA0, 3'd3, 0, 1, 2'd2, 0);
        step("fill_full",     1, 1, 0, 0, 8'hCA, 8'hA0, 3'd4, 0, 0, 2'd3, 0);
        step("full_blocked",  1, 1, 0, 0, 8'hCA, 8'hA0, 3'd4, 0, 0, 2'd3, 0);
        step("full_res_n",    0, 0, 1, 0, 8'hCA, 8'h50, 3'd3, 0, 1, 2'd3, 0);
        step("sim_acc_res_a", 1, 1, 1, 0, 8'hE5, 8'h28, 3'd3, 0, 1, 2'd0, 0);
        step("sim_acc_res_b", 1, 0, 1, 1, 8'h72, 8'h94, 3'd3, 0, 1, 2'd1, 0);
        step("drain_t",       0, 0, 1, 1, 8'h72, 8'hCA, 3'd2, 0, 1, 2'd1, 0);
        step("drain_t2",      0, 0, 1, 1, 8'h72, 8'hE5, 3'd1, 0, 1, 2'd1, 0);
        step("drain_n",       0, 0, 1, 0, 8'h72, 8'h72, 3'd0, 0, 1, 2'd1, 0);

        step("mp_acc_a",      1, 1, 0, 0, 8'hB9, 8'h72, 3'd1, 0, 1, 2'd2, 0);
        step("mp_acc_b",      1, 1, 0, 0, 8'hDC, 8'h72, 3'd2, 0, 1, 2'd3, 0);
        step("mp_acc_c",      1, 1, 0, 0, 8'hEE, 8'h72, 3'd3, 0, 1, 2'd0, 0);
        step("mp_resolve",    0, 0, 1, 0, 8'h39, 8'h39, 3'd0, 1, 0, 2'd0, 0);
        step("recover_res",   1, 1, 1, 1, 8'h39, 8'h39, 3'd0, 0, 1, 2'd0, 1);
        step("sq_acc",        1, 1, 0, 0, 8'h9C, 8'h39, 3'd1, 0, 1, 2'd1, 1);
        step("sq_acc_mp",     1, 1, 1, 0, 8'h1C, 8'h1C, 3'd0, 1, 0, 2'd0, 1);
        step("sq_recover",    0, 0, 0, 0, 8'h1C, 8'h1C, 3'd0, 0, 1, 2'd0, 1);

        step("pre_rst_a",     1, 1, 0, 0, 8'h8E, 8'h1C, 3'd1, 0, 1, 2'd1, 1);
        step("pre_rst_b",     1, 0, 0, 0, 8'h47, 8'h1C, 3'd2, 0, 1, 2'd2, 1);

        // Reset asserted between edges must clear everything before the next posedge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        expect_state("async_rst", 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 2'd0, 1'b0);
        -> sample_ev;
        @(negedge clk);
        rst = 1'b0;

        step("empty_res",     0, 0, 1, 1, 8'h00, 8'h00, 3'd0, 0, 1, 2'd0, 1);
        step("err_sticky",    0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 1, 2'd0, 1);

        // Give the monitor a bounded window to drain the queue.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
